// File: rtl/alu_operand_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_operand_seq
// Brief   : Debounced button sequencer that captures ALU operands A, B and the
//           opcode into held registers, flagging a complete triple with valid.
// Revision: 1.0 - initial release
// ============================================================================
module alu_operand_seq #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_data,
    input  logic [2:0] sw_op,
    input  logic       btn_next,
    input  logic       btn_clr,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    output logic       out_valid,
    output logic [1:0] phase
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_wait_a  = 2'd0;
    localparam logic [1:0] c_wait_b  = 2'd1;
    localparam logic [1:0] c_wait_op = 2'd2;
    localparam logic [1:0] c_show    = 2'd3;

    logic [1:0] w_btn_raw;
    logic [1:0] w_press;
    logic       w_next_pulse;
    logic       w_clr_pulse;

    assign w_btn_raw = {btn_clr, btn_next};

    // Identical synchronizer + debouncer per button; bit 0 next, bit 1 clear.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
            logic             r_meta;
            logic             r_sync;
            logic             r_stable;
            logic             r_stable_d;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_meta     <= 1'b0;
                    r_sync     <= 1'b0;
                    r_stable   <= 1'b0;
                    r_stable_d <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_meta     <= w_btn_raw[gi];
                    r_sync     <= r_meta;
                    r_stable_d <= r_stable;
                    if (r_sync != r_stable) begin
                        if (r_cnt == c_cnt_max) begin
                            r_stable <= r_sync;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_press[gi] = r_stable & ~r_stable_d;
        end
    endgenerate

    assign w_next_pulse = w_press[0];
    assign w_clr_pulse  = w_press[1];

    logic [1:0] r_phase;
    logic [1:0] w_phase_nxt;
    logic [3:0] r_alu_a;
    logic [3:0] w_alu_a_nxt;
    logic [3:0] r_alu_b;
    logic [3:0] w_alu_b_nxt;
    logic [2:0] r_alu_op;
    logic [2:0] w_alu_op_nxt;
    logic       r_valid;
    logic       w_valid_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase  <= c_wait_a;
            r_alu_a  <= 4'd0;
            r_alu_b  <= 4'd0;
            r_alu_op <= 3'd0;
            r_valid  <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_alu_a  <= w_alu_a_nxt;
            r_alu_b  <= w_alu_b_nxt;
            r_alu_op <= w_alu_op_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        if (w_clr_pulse) begin
            w_phase_nxt = c_wait_a;
        end else if (w_next_pulse) begin
            case (r_phase)
                c_wait_a:  w_phase_nxt = c_wait_b;
                c_wait_b:  w_phase_nxt = c_wait_op;
                c_wait_op: w_phase_nxt = c_show;
                default:   w_phase_nxt = c_wait_a;
            endcase
        end
    end

    // Captured values hold across phases; leaving SHOW only drops valid.
    always_comb begin
        w_alu_a_nxt  = r_alu_a;
        w_alu_b_nxt  = r_alu_b;
        w_alu_op_nxt = r_alu_op;
        w_valid_nxt  = r_valid;
        if (w_clr_pulse) begin
            w_alu_a_nxt  = 4'd0;
            w_alu_b_nxt  = 4'd0;
            w_alu_op_nxt = 3'd0;
            w_valid_nxt  = 1'b0;
        end else if (w_next_pulse) begin
            case (r_phase)
                c_wait_a:  w_alu_a_nxt = sw_data;
                c_wait_b:  w_alu_b_nxt = sw_data;
                c_wait_op: begin
                    w_alu_op_nxt = sw_op;
                    w_valid_nxt  = 1'b1;
                end
                default:   w_valid_nxt = 1'b0;
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign out_valid = r_valid;
    assign phase     = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_operand_seq
// Brief   : Scoreboard bench for alu_operand_seq; expected output snapshots and
//           their change cycle are queued by stimulus and popped by a monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_operand_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_data;
    logic [2:0] sw_op;
    logic       btn_next;
    logic       btn_clr;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic       out_valid;
    logic [1:0] phase;

    alu_operand_seq #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_data  (sw_data),
        .sw_op    (sw_op),
        .btn_next (btn_next),
        .btn_clr  (btn_clr),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .out_valid(out_valid),
        .phase    (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [13:0] val;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic [13:0] prev;

    function automatic logic [13:0] pk(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op, input logic v,
                                       input logic [1:0] ph);
        return {a, b, op, v, ph};
    endfunction

    function automatic string fmt(input logic [13:0] x);
        return $sformatf("a=%h b=%h op=%0d v=%b ph=%0d",
                         x[13:10], x[9:6], x[5:3], x[2], x[1:0]);
    endfunction

    function automatic logic [13:0] snap();
        return {alu_a, alu_b, alu_op, out_valid, phase};
    endfunction

    // Monitor: every observable output change must match the next queued entry.
    always @(negedge clk) begin
        logic [13:0] cur;
        exp_t        e;
        if (mon_en) begin
            cur = snap();
            if (cur !== prev) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got {%s} required no change from {%s}",
                             cyc, fmt(cur), fmt(prev));
                end else begin
                    e = sb.pop_front();
                    if (cur !== e.val || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL output_change got {%s} at cyc %0d required {%s} at cyc %0d",
                                 fmt(cur), cyc, fmt(e.val), e.cyc);
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_at(input logic [13:0] v, input int delay);
        exp_t e;
        e.val = v;
        e.cyc = cyc + delay;
        sb.push_back(e);
    endtask

    // Clean press: first sampling edge is cyc+1, capture lands on edge cyc+7.
    task automatic press(input int len, input logic [13:0] v);
        expect_at(v, 7);
        btn_next = 1'b1;
        tick(len);
        btn_next = 1'b0;
        tick(20);
    endtask

    initial begin
        logic [7:0] bounce;
        rst_n    = 1'b0;
        sw_data  = 4'h0;
        sw_op    = 3'd0;
        btn_next = 1'b0;
        btn_clr  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            btn_next = ~btn_next;
            btn_clr  = ~btn_clr;
        end
        checks++;
        if (snap() !== 14'd0) begin
            errors++;
            $display("FAIL reset_state got {%s} required all zero", fmt(snap()));
        end

        rst_n    = 1'b1;
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        prev     = 14'd0;
        mon_en   = 1'b1;
        tick(50);

        sw_data = 4'h5; press(10, pk(4'h5, 4'h0, 3'd0, 1'b0, 2'd1));
        sw_data = 4'h3; press(10, pk(4'h5, 4'h3, 3'd0, 1'b0, 2'd2));
        sw_op   = 3'd1; press(10, pk(4'h5, 4'h3, 3'd1, 1'b1, 2'd3));
        press(10, pk(4'h5, 4'h3, 3'd1, 1'b0, 2'd0));

        sw_data = 4'h9; press(200, pk(4'h9, 4'h3, 3'd1, 1'b0, 2'd1));

        bounce = 8'b1110_1101;
        for (int i = 0; i < 8; i++) begin
            btn_next = bounce[i];
            tick(1);
        end
        btn_next = 1'b0;
        tick(15);
        sw_data = 4'h6; press(6, pk(4'h9, 4'h6, 3'd1, 1'b0, 2'd2));

        expect_at(14'd0, 7);
        btn_next = 1'b1;
        btn_clr  = 1'b1;
        tick(6);
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        tick(20);

        sw_data = 4'h9; press(10, pk(4'h9, 4'h0, 3'd0, 1'b0, 2'd1));
        sw_data = 4'h6; press(10, pk(4'h9, 4'h6, 3'd0, 1'b0, 2'd2));
        sw_op   = 3'd7; press(10, pk(4'h9, 4'h6, 3'd7, 1'b1, 2'd3));
        press(10, pk(4'h9, 4'h6, 3'd7, 1'b0, 2'd0));
        sw_data = 4'h4; press(10, pk(4'h4, 4'h6, 3'd7, 1'b0, 2'd1));

        expect_at(14'd0, 1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(10);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_changes got %0d pending entries required 0, next {%s}",
                     sb.size(), fmt(sb[0].val));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
